fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage of the 4-bit CPU, directly upstream of `control_unit`. Holds the program counter, fetches 8-bit instructions from instruction memory over a req/valid handshake, and presents `opcode`/`imm` to the control unit and datapath. Consumes the control unit's `jmp_sel` to select the next PC: branch target from `imm`, or sequential.

## Interface
- `PC_W`, default 4: program counter width; instruction memory depth is 2^PC_W.
- `INSTR_W`, default 8: instruction width; `opcode` = [7:4], `imm` = [3:0].
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_addr`  out  PC_W  instruction address; equals current PC.
- `imem_req`  out  1  fetch request; held until `imem_valid` is sampled high.
- `imem_rdata`  in  INSTR_W  instruction word; sampled only when `imem_req && imem_valid`.
- `imem_valid`  in  1  memory data valid.
- `jmp_sel`  in  1  from `control_unit`; combinational on the currently presented `opcode`.
- `stall`  in  1  downstream not ready; holds the current instruction.
- `opcode`  out  4  instruction register [7:4].
- `imm`  out  4  instruction register [3:0].
- `instr_valid`  out  1  `opcode`/`imm` hold a live instruction.
- `pc`  out  PC_W  current program counter (debug/observability).

## Operation
- States: RST, FETCH, ISSUE, plus HALT when `FETCH_HALT_EN` is defined.
- RST: entered asynchronously on `rst_n` low. Outputs: `pc`=0, `imem_req`=0, `instr_valid`=0, `opcode`=0, `imm`=0. On the first edge after deassertion, go to FETCH.
- FETCH: `imem_req`=1 and `imem_addr`=`pc`, both stable. On an edge with `imem_valid`=1, load `imem_rdata` into the instruction register and go to ISSUE. Otherwise stay.
- ISSUE: `instr_valid`=1 and `imem_req`=0.
  - With `stall`=1: hold state, PC and instruction register.
  - With `stall`=0, the instruction retires on that edge:
    - `pc` <= `jmp_sel` ? zero-extended `imm` : `pc`+1, modulo 2^PC_W.
    - Go to FETCH.
- PC wrap-around: `pc` = 2^PC_W-1 plus sequential advance gives 0. No error is flagged.
- Jump to self (`imm` == `pc`) is legal and refetches the same address.
- `imem_valid` while `imem_req`=0 is ignored.
- `stall` in FETCH is ignored. It only gates retirement in ISSUE.
- `instr_valid`=0 outside ISSUE. `opcode`/`imm` keep their last loaded value.

## Timing
- Minimum 2 cycles per instruction: 1 FETCH cycle with `imem_valid` already high, then 1 ISSUE cycle.
- Each memory wait cycle adds 1 cycle. Each stall cycle adds 1 cycle.
- `jmp_sel` is sampled on the retiring ISSUE edge. The new `imem_addr` is visible in the cycle immediately after that edge.
- The flags `cf`/`sf`/`zf` seen by the control unit must be stable in ISSUE. The flags register updates on the same retire edge, so a branch sees the flags from the previous instruction.
- Reset mid-fetch: `imem_req` drops immediately (asynchronously). A pending memory response is abandoned, and the memory must tolerate the abandoned request.
- Reset in ISSUE: `instr_valid` drops immediately. The instruction does not retire.

## Configuration
- `FETCH_HALT_EN` defined:
  - Opcode 4'b1111 retiring from ISSUE moves to HALT; `pc` does not advance.
  - HALT: `imem_req`=0, `instr_valid`=0, `opcode`/`imm` hold 4'b1111/imm. Exit only via reset.
- `FETCH_HALT_EN` not defined:
  - 4'b1111 is treated as any other opcode (PC advances per `jmp_sel`).
  - HALT state logic is absent.

## Structure
- Shared package `cpu_pkg` holds:
  - `PC_W`/`INSTR_W` defaults;
  - opcode field positions;
  - `OP_HALT` = 4'b1111;
  - fetch state encodings (RST, FETCH, ISSUE, HALT).
  - `control_unit` reuses the opcode constants from the same package.
- One sub-module, `program_counter`:
  - inputs: `clk`, `rst_n`, advance enable, `jmp_sel`, target;
  - handles increment, wrap and load.
- The FSM and instruction register live in `fetch_unit` top.

## Test plan
- Reset, then memory returns 0x10, 0x40, 0x51 with `imem_valid` always high and `jmp_sel`=0:
  - addresses requested are 0, 1, 2;
  - `opcode` = 1, 4, 5 in consecutive ISSUE cycles 2 clocks apart.
- Memory delays `imem_valid` by 3 cycles:
  - `imem_req` and `imem_addr`=0 stay stable for all 4 FETCH cycles;
  - `instr_valid` rises on the cycle after `imem_valid` is accepted.
- Instruction 0x97 at pc=2 with `jmp_sel`=1:
  - next `imem_addr`=7.
  - Same instruction with `jmp_sel`=0: next `imem_addr`=3.
- `stall` held 4 cycles in ISSUE:
  - `opcode`/`imm`/`pc` unchanged and `imem_req`=0 throughout;
  - the PC advances once, on the edge where `stall` drops.
- pc=15 with sequential advance gives `imem_addr`=0. Reset asserted mid-FETCH:
  - `imem_req`=0, `pc`=0, `instr_valid`=0 immediately;
  - fetch restarts at address 0 after release.
- With `FETCH_HALT_EN`, instruction 0xF0 retires:
  - no further `imem_req`, `instr_valid`=0 forever;
  - reset restarts fetch at address 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU: default widths, instruction field
// positions, the halt opcode and the fetch-stage state encodings.
// control_unit imports this package for the opcode constants.
package cpu_pkg;

    localparam int PC_W_DEF    = 4;
    localparam int INSTR_W_DEF = 8;

    // Instruction field positions: opcode in the upper nibble, immediate below.
    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 4;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/program_counter.sv
// Program counter for the fetch stage. On an advance it either loads the
// zero-extended branch target or steps by one, wrapping modulo 2^PC_W.
module program_counter
    import cpu_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_adv,
    input  logic            i_jmp_sel,
    input  logic [3:0]      i_target,
    output logic [PC_W-1:0] o_pc
);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_pc_next;

    // Resize the 4-bit immediate to the PC width (zero-extend or truncate).
    assign w_target = PC_W'(i_target);

    // Select the next PC: hold, branch target, or sequential step with wrap.
    always_comb begin
        w_pc_next = r_pc;
        if (i_adv) begin
            if (i_jmp_sel) begin
                w_pc_next = w_target;
            end else begin
                w_pc_next = r_pc + PC_W'(1);
            end
        end
    end

    // PC register, cleared asynchronously so fetch restarts at address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= '0;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetch FSM, instruction register and the program
// counter instance. Requests the word at pc, latches it on imem_valid, then
// presents opcode/imm until it retires (stall low), picking the next PC from
// jmp_sel. Optional halt support is built when FETCH_HALT_EN is defined:
// opcode 4'b1111 retiring parks the stage in HALT until reset.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PC_W-1:0]    imem_addr,
    output logic               imem_req,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    input  logic               jmp_sel,
    input  logic               stall,
    output logic [3:0]         opcode,
    output logic [3:0]         imm,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc
);

    fetch_state_t       r_state;
    fetch_state_t       w_state_next;
    logic [INSTR_W-1:0] r_instr;
    logic               w_load_ir;
    logic               w_adv;
    logic [PC_W-1:0]    w_pc;

    program_counter #(
        .PC_W (PC_W)
    ) u_pc (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_adv     (w_adv),
        .i_jmp_sel (jmp_sel),
        .i_target  (r_instr[IMM_MSB:IMM_LSB]),
        .o_pc      (w_pc)
    );

    // State register; reset drops straight into RST so req/valid fall at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RST;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic plus the IR load and PC advance strobes.
    always_comb begin
        w_state_next = r_state;
        w_load_ir    = 1'b0;
        w_adv        = 1'b0;
        case (r_state)
            ST_RST: begin
                w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                // stall is deliberately ignored here; only memory gates fetch.
                if (imem_valid) begin
                    w_load_ir    = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!stall) begin
`ifdef FETCH_HALT_EN
                    if (r_instr[OPC_MSB:OPC_LSB] == OP_HALT) begin
                        // Halt retires without moving the PC.
                        w_state_next = ST_HALT;
                    end else begin
                        w_adv        = 1'b1;
                        w_state_next = ST_FETCH;
                    end
`else
                    w_adv        = 1'b1;
                    w_state_next = ST_FETCH;
`endif
                end
            end
`ifdef FETCH_HALT_EN
            ST_HALT: begin
                w_state_next = ST_HALT;
            end
`endif
            default: begin
                w_state_next = ST_RST;
            end
        endcase
    end

    // Instruction register; keeps its last value outside ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= '0;
        end else if (w_load_ir) begin
            r_instr <= imem_rdata;
        end
    end

    // Handshake and status outputs decoded straight from the state register.
    always_comb begin
        imem_req    = (r_state == ST_FETCH);
        instr_valid = (r_state == ST_ISSUE);
    end

    assign imem_addr = w_pc;
    assign pc        = w_pc;
    assign opcode    = r_instr[OPC_MSB:OPC_LSB];
    assign imm       = r_instr[IMM_MSB:IMM_LSB];

endmodule
